// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared playfield constants, cell codes and coordinate types
package snake_pkg;
  localparam int GRID_WIDTH_DFLT     = 32;
  localparam int GRID_HEIGHT_DFLT    = 24;
  localparam int BITS_PER_BLOCK_DFLT = 2;
  localparam int ROW_W = $clog2(GRID_HEIGHT_DFLT);
  localparam int COL_W = $clog2(GRID_WIDTH_DFLT);

  typedef logic [ROW_W-1:0]               row_t;
  typedef logic [COL_W-1:0]               col_t;
  typedef logic [BITS_PER_BLOCK_DFLT-1:0] block_t;

  localparam block_t BLOCK_EMPTY = 2'd0;
  localparam block_t BLOCK_WALL  = 2'd1;
  localparam block_t BLOCK_SNAKE = 2'd2;
  localparam block_t BLOCK_FOOD  = 2'd3;
endpackage

// File: rtl/food_placer_if.sv
// rtl/food_placer_if.sv - request, grid-port and food-status signals of the food placer
interface food_placer_if
  import snake_pkg::*;
#(
  parameter int GRID_WIDTH     = GRID_WIDTH_DFLT,
  parameter int GRID_HEIGHT    = GRID_HEIGHT_DFLT,
  parameter int BITS_PER_BLOCK = BITS_PER_BLOCK_DFLT
) ();
  localparam int VW = $clog2(GRID_HEIGHT);
  localparam int HW = $clog2(GRID_WIDTH);

  logic                      PlaceReq;
  logic [VW-1:0]             CandV;
  logic [HW-1:0]             CandH;
  logic                      GridBusy;
  logic                      RdEn;
  logic [VW-1:0]             RdV;
  logic [HW-1:0]             RdH;
  logic [BITS_PER_BLOCK-1:0] RdData;
  logic                      WrEn;
  logic [VW-1:0]             WrV;
  logic [HW-1:0]             WrH;
  logic [BITS_PER_BLOCK-1:0] WrData;
  logic                      Busy;
  logic                      PlaceDone;
  logic                      PlaceFail;
  logic                      FoodValid;
  logic [VW-1:0]             FoodV;
  logic [HW-1:0]             FoodH;

  modport slave (
    input  PlaceReq, CandV, CandH, GridBusy, RdData,
    output RdEn, RdV, RdH, WrEn, WrV, WrH, WrData,
    output Busy, PlaceDone, PlaceFail, FoodValid, FoodV, FoodH
  );

  modport master (
    output PlaceReq, CandV, CandH, GridBusy, RdData,
    input  RdEn, RdV, RdH, WrEn, WrV, WrH, WrData,
    input  Busy, PlaceDone, PlaceFail, FoodValid, FoodV, FoodH
  );
endinterface

// File: rtl/food_scan_counter.sv
// rtl/food_scan_counter.sv - row-major walk over the interior cells, starting at (1,1)
module food_scan_counter
  import snake_pkg::*;
#(
  parameter int GRID_WIDTH  = GRID_WIDTH_DFLT,
  parameter int GRID_HEIGHT = GRID_HEIGHT_DFLT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic                           advance,
  output logic [$clog2(GRID_HEIGHT)-1:0] scan_v,
  output logic [$clog2(GRID_WIDTH)-1:0]  scan_h,
  output logic                           last
);
  localparam int VW = $clog2(GRID_HEIGHT);
  localparam int HW = $clog2(GRID_WIDTH);
  localparam logic [VW-1:0] V_MAX = VW'(GRID_HEIGHT - 2);
  localparam logic [HW-1:0] H_MAX = HW'(GRID_WIDTH - 2);

  logic [VW-1:0] v_q, v_d;
  logic [HW-1:0] h_q, h_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      h_q <= '0;
    end else begin
      v_q <= v_d;
      h_q <= h_d;
    end
  end

  always_comb begin
    v_d = v_q;
    h_d = h_q;
    if (load) begin
      v_d = VW'(1);
      h_d = HW'(1);
    end else if (advance) begin
      if (h_q == H_MAX) begin
        h_d = HW'(1);
        v_d = v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  assign scan_v = v_q;
  assign scan_h = h_q;
  assign last   = (v_q == V_MAX) && (h_q == H_MAX);
endmodule

// File: rtl/food_placer.sv
// rtl/food_placer.sv - finds an empty interior cell (random tries, then linear scan) and writes food there
module food_placer
  import snake_pkg::*;
#(
  parameter int GRID_WIDTH     = GRID_WIDTH_DFLT,
  parameter int GRID_HEIGHT    = GRID_HEIGHT_DFLT,
  parameter int BITS_PER_BLOCK = BITS_PER_BLOCK_DFLT,
  parameter int MAX_TRIES      = 16
) (
  input  logic         MasterClock,
  input  logic         Reset,
  food_placer_if.slave bus
);
  localparam int VW = $clog2(GRID_HEIGHT);
  localparam int HW = $clog2(GRID_WIDTH);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [VW-1:0] V_MAX     = VW'(GRID_HEIGHT - 2);
  localparam logic [HW-1:0] H_MAX     = HW'(GRID_WIDTH - 2);
  localparam logic [TW-1:0] TRIES_LIM = TW'(MAX_TRIES);
  localparam logic [BITS_PER_BLOCK-1:0] CODE_EMPTY = BITS_PER_BLOCK'(BLOCK_EMPTY);
  localparam logic [BITS_PER_BLOCK-1:0] CODE_FOOD  = BITS_PER_BLOCK'(BLOCK_FOOD);

  typedef enum logic [3:0] {
    S_IDLE, S_SAMPLE, S_READ, S_CHECK, S_SCAN_READ, S_SCAN_CHECK, S_WRITE, S_DONE, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tries_q, tries_d, tries_inc;
  logic [VW-1:0] cand_v_q, cand_v_d, found_v_q, found_v_d, food_v_q, food_v_d;
  logic [HW-1:0] cand_h_q, cand_h_d, found_h_q, found_h_d, food_h_q, food_h_d;
  logic          food_valid_q, food_valid_d;
  logic          retry, scan_load, scan_adv, scan_last, cand_interior;
  logic [VW-1:0] scan_v;
  logic [HW-1:0] scan_h;

  logic                      rd_en, wr_en;
  logic [VW-1:0]             rd_v, wr_v;
  logic [HW-1:0]             rd_h, wr_h;
  logic [BITS_PER_BLOCK-1:0] wr_data;

  food_scan_counter #(
    .GRID_WIDTH  (GRID_WIDTH),
    .GRID_HEIGHT (GRID_HEIGHT)
  ) u_scan (
    .clk     (MasterClock),
    .rst     (Reset),
    .load    (scan_load),
    .advance (scan_adv),
    .scan_v  (scan_v),
    .scan_h  (scan_h),
    .last    (scan_last)
  );

  assign tries_inc     = tries_q + TW'(1);
  assign cand_interior = (bus.CandV != '0) && (bus.CandV <= V_MAX) &&
                         (bus.CandH != '0) && (bus.CandH <= H_MAX);

  always_ff @(posedge MasterClock or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      tries_q      <= '0;
      cand_v_q     <= '0;
      cand_h_q     <= '0;
      found_v_q    <= '0;
      found_h_q    <= '0;
      food_v_q     <= '0;
      food_h_q     <= '0;
      food_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      cand_v_q     <= cand_v_d;
      cand_h_q     <= cand_h_d;
      found_v_q    <= found_v_d;
      found_h_q    <= found_h_d;
      food_v_q     <= food_v_d;
      food_h_q     <= food_h_d;
      food_valid_q <= food_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    cand_v_d     = cand_v_q;
    cand_h_d     = cand_h_q;
    found_v_d    = found_v_q;
    found_h_d    = found_h_q;
    food_v_d     = food_v_q;
    food_h_d     = food_h_q;
    food_valid_d = food_valid_q;
    retry        = 1'b0;
    scan_load    = 1'b0;
    scan_adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.PlaceReq) begin
          state_d = S_SAMPLE;
          tries_d = '0;
        end
      end
      S_SAMPLE: begin
        cand_v_d = bus.CandV;
        cand_h_d = bus.CandH;
        if (cand_interior) state_d = S_READ;
        else               retry   = 1'b1;
      end
      S_READ: begin
        if (!bus.GridBusy) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (bus.RdData == CODE_EMPTY) begin
          found_v_d = cand_v_q;
          found_h_d = cand_h_q;
          state_d   = S_WRITE;
        end else begin
          retry = 1'b1;
        end
      end
      S_SCAN_READ: begin
        if (!bus.GridBusy) state_d = S_SCAN_CHECK;
      end
      S_SCAN_CHECK: begin
        if (bus.RdData == CODE_EMPTY) begin
          found_v_d = scan_v;
          found_h_d = scan_h;
          state_d   = S_WRITE;
        end else if (scan_last) begin
          state_d = S_FAIL;
        end else begin
          scan_adv = 1'b1;
          state_d  = S_SCAN_READ;
        end
      end
      S_WRITE: begin
        if (!bus.GridBusy) begin
          food_v_d     = found_v_q;
          food_h_d     = found_h_q;
          food_valid_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Running out of random tries hands over to the exhaustive scan.
    if (retry) begin
      tries_d = tries_inc;
      if (tries_inc == TRIES_LIM) begin
        state_d   = S_SCAN_READ;
        scan_load = 1'b1;
      end else begin
        state_d = S_SAMPLE;
      end
    end
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_v    = '0;
    rd_h    = '0;
    wr_en   = 1'b0;
    wr_v    = '0;
    wr_h    = '0;
    wr_data = '0;
    case (state_q)
      S_READ: begin
        rd_en = ~bus.GridBusy;
        rd_v  = cand_v_q;
        rd_h  = cand_h_q;
      end
      S_SCAN_READ: begin
        rd_en = ~bus.GridBusy;
        rd_v  = scan_v;
        rd_h  = scan_h;
      end
      S_WRITE: begin
        wr_en   = ~bus.GridBusy;
        wr_v    = found_v_q;
        wr_h    = found_h_q;
        wr_data = CODE_FOOD;
      end
      default: ;
    endcase
  end

  assign bus.RdEn      = rd_en;
  assign bus.RdV       = rd_v;
  assign bus.RdH       = rd_h;
  assign bus.WrEn      = wr_en;
  assign bus.WrV       = wr_v;
  assign bus.WrH       = wr_h;
  assign bus.WrData    = wr_data;
  assign bus.Busy      = (state_q != S_IDLE);
  assign bus.PlaceDone = (state_q == S_DONE);
  assign bus.PlaceFail = (state_q == S_FAIL);
  assign bus.FoodValid = food_valid_q;
  assign bus.FoodV     = food_v_q;
  assign bus.FoodH     = food_h_q;
endmodule

// File: tb/tb_food_placer.sv
// tb/tb_food_placer.sv - self-checking bench for food_placer with a grid-store model
module tb_food_placer;
  import snake_pkg::*;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int MT = 4;
  localparam int NCELLS = (GH - 2) * (GW - 2);

  logic clk, rst;
  food_placer_if #(.GRID_WIDTH(GW), .GRID_HEIGHT(GH), .BITS_PER_BLOCK(2)) bus ();

  food_placer #(
    .GRID_WIDTH(GW), .GRID_HEIGHT(GH), .BITS_PER_BLOCK(2), .MAX_TRIES(MT)
  ) dut (
    .MasterClock (clk),
    .Reset       (rst),
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  block_t grid [GH][GW];
  row_t   rd_log_v [$];
  col_t   rd_log_h [$];
  int     wr_cnt = 0, done_cnt = 0, fail_cnt = 0, viol = 0;
  row_t   wr_v = '0;
  col_t   wr_h = '0;
  block_t wr_d = '0;

  always @(posedge clk) begin
    if (bus.RdEn) begin
      rd_log_v.push_back(bus.RdV);
      rd_log_h.push_back(bus.RdH);
      bus.RdData <= grid[bus.RdV][bus.RdH];
    end
    if (bus.WrEn) begin
      wr_cnt <= wr_cnt + 1;
      wr_v   <= bus.WrV;
      wr_h   <= bus.WrH;
      wr_d   <= bus.WrData;
    end
    if ((bus.RdEn && bus.WrEn) || ((bus.RdEn || bus.WrEn) && bus.GridBusy)) viol <= viol + 1;
    if (bus.PlaceDone) done_cnt <= done_cnt + 1;
    if (bus.PlaceFail) fail_cnt <= fail_cnt + 1;
  end

  int   errors = 0, checks = 0;
  int   lat;
  bit   got_done, got_fail;
  int   wr0, done0, fail0, viol0, rd0;
  bit   exp_val = 1'b0;
  int   exp_fv = 0, exp_fh = 0;
  logic rec_rden [64];
  logic rec_wren [64];
  row_t rec_rdv [64];
  col_t rec_rdh [64];
  row_t rec_wrv [64];
  col_t rec_wrh [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cell(input int v, input int h, input block_t c);
    grid[5'(v)][5'(h)] = c;
  endtask

  function automatic block_t get_cell(input int v, input int h);
    return grid[5'(v)][5'(h)];
  endfunction

  task automatic fill(input int dens);
    for (int v = 0; v < GH; v++)
      for (int h = 0; h < GW; h++)
        if (v == 0 || v == GH-1 || h == 0 || h == GW-1) set_cell(v, h, BLOCK_WALL);
        else if (int'($urandom_range(99)) < dens)       set_cell(v, h, BLOCK_SNAKE);
        else                                           set_cell(v, h, BLOCK_EMPTY);
  endtask

  // Reference: first empty random candidate wins, else first empty cell in row-major order.
  function automatic void model(input int cv, input int ch, output bit ok,
                                output int ev, output int eh, output int elat);
    bit in_b = (cv >= 1 && cv <= GH-2 && ch >= 1 && ch <= GW-2);
    int t = MT * (in_b ? 3 : 1);
    int n = 0;
    ok = 0; ev = 0; eh = 0;
    if (in_b && get_cell(cv, ch) == BLOCK_EMPTY) begin
      ok = 1; ev = cv; eh = ch; elat = 4;
      return;
    end
    elat = t + 2 * NCELLS;
    for (int v = 1; v <= GH-2; v++)
      for (int h = 1; h <= GW-2; h++) begin
        if (!ok && get_cell(v, h) == BLOCK_EMPTY) begin
          ok = 1; ev = v; eh = h; elat = t + 2 * (n + 1) + 1;
        end
        n++;
      end
  endfunction

  task automatic snap();
    wr0 = wr_cnt; done0 = done_cnt; fail0 = fail_cnt; viol0 = viol; rd0 = rd_log_v.size();
  endtask

  task automatic run_place(input int chg_at, input int cv2, input int ch2,
                           input int w0s, input int w0e, input int w1s, input int w1e,
                           input bit rnd_busy);
    lat = 0;
    @(negedge clk) bus.PlaceReq = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.PlaceReq = 1'b0;
    while (lat < 4000) begin
      bus.GridBusy = (lat >= w0s && lat < w0e) || (lat >= w1s && lat < w1e) ||
                     (rnd_busy && $urandom_range(3) == 0);
      if (lat == chg_at) begin
        bus.CandV = 5'(cv2);
        bus.CandH = 5'(ch2);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat < 64) begin
        rec_rden[6'(lat)] = bus.RdEn; rec_rdv[6'(lat)] = bus.RdV; rec_rdh[6'(lat)] = bus.RdH;
        rec_wren[6'(lat)] = bus.WrEn; rec_wrv[6'(lat)] = bus.WrV; rec_wrh[6'(lat)] = bus.WrH;
      end
      if (bus.PlaceDone || bus.PlaceFail) break;
    end
    got_done = bus.PlaceDone;
    got_fail = bus.PlaceFail;
    bus.GridBusy = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_result(input string tag, input bit ok, input int ev, input int eh,
                               input int elat, input bit chk_lat);
    chk($sformatf("%s.kind", tag), 32'({got_done, got_fail}), ok ? 2 : 1);
    chk($sformatf("%s.wrcnt", tag), wr_cnt - wr0, ok ? 1 : 0);
    if (ok) begin
      chk($sformatf("%s.wraddr", tag), 32'({wr_v, wr_h}), (ev << 5) | eh);
      chk($sformatf("%s.wrdata", tag), 32'(wr_d), 32'(BLOCK_FOOD));
      exp_val = 1'b1; exp_fv = ev; exp_fh = eh;
    end
    chk($sformatf("%s.food", tag), 32'({bus.FoodValid, bus.FoodV, bus.FoodH}),
        (32'(exp_val) << 10) | (exp_fv << 5) | exp_fh);
    chk($sformatf("%s.pulses", tag), ((done_cnt - done0) << 4) | (fail_cnt - fail0),
        ok ? 32'h10 : 32'h01);
    chk($sformatf("%s.viol", tag), viol - viol0, 0);
    chk($sformatf("%s.idle", tag), 32'({bus.Busy, bus.PlaceDone, bus.PlaceFail}), 0);
    if (chk_lat) chk($sformatf("%s.latency", tag), lat, elat);
  endtask

  initial begin
    bit ok;
    int ev, eh, elat, cv, ch;

    rst = 1'b1;
    bus.PlaceReq = 1'b1;
    bus.CandV = '0;
    bus.CandH = '0;
    bus.GridBusy = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.status", 32'({bus.Busy, bus.PlaceDone, bus.PlaceFail, bus.FoodValid}), 0);
    chk("reset.strobes", 32'({bus.RdEn, bus.WrEn, bus.WrData}), 0);
    chk("reset.addr", 32'({bus.RdV, bus.RdH, bus.WrV, bus.WrH}), 0);
    chk("reset.food", 32'({bus.FoodV, bus.FoodH}), 0);
    bus.PlaceReq = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.busy", 32'(bus.Busy), 0);

    // Best case on an empty interior.
    bus.CandV = 5'd5; bus.CandH = 5'd7;
    snap();
    run_place(-1, 0, 0, 0, 0, 0, 0, 1'b0);
    chk("best.rdcnt", rd_log_v.size() - rd0, 1);
    if (rd_log_v.size() > rd0) chk("best.rdaddr", 32'({rd_log_v[rd0], rd_log_h[rd0]}), (5 << 5) | 7);
    expect_result("best", 1'b1, 5, 7, 4, 1'b1);

    // One border candidate, then an interior one.
    fill(0);
    bus.CandV = 5'd0; bus.CandH = 5'd7;
    snap();
    run_place(1, 3, 3, 0, 0, 0, 0, 1'b0);
    chk("oob.rdcnt", rd_log_v.size() - rd0, 1);
    if (rd_log_v.size() > rd0) chk("oob.rdaddr", 32'({rd_log_v[rd0], rd_log_h[rd0]}), (3 << 5) | 3);
    expect_result("oob", 1'b1, 3, 3, 5, 1'b1);

    // GridBusy stalls: 10 cycles in READ, 3 in WRITE.
    fill(0);
    bus.CandV = 5'd5; bus.CandH = 5'd7;
    snap();
    run_place(-1, 0, 0, 1, 11, 13, 16, 1'b0);
    chk("stall.read5", 32'({rec_rden[5], rec_rdv[5], rec_rdh[5]}), (5 << 5) | 7);
    chk("stall.read11", 32'({rec_rden[11], rec_rdv[11], rec_rdh[11]}), (5 << 5) | 7);
    chk("stall.write15", 32'({rec_wren[15], rec_wrv[15], rec_wrh[15]}), (5 << 5) | 7);
    chk("stall.rdcnt", rd_log_v.size() - rd0, 1);
    expect_result("stall", 1'b1, 5, 7, 17, 1'b1);

    // Candidate stuck on snake: MT random reads then scan from (1,1).
    fill(0);
    set_cell(6, 6, BLOCK_SNAKE);
    set_cell(1, 1, BLOCK_SNAKE);
    bus.CandV = 5'd6; bus.CandH = 5'd6;
    snap();
    run_place(-1, 0, 0, 0, 0, 0, 0, 1'b0);
    chk("scan.rdcnt", rd_log_v.size() - rd0, MT + 2);
    if (rd_log_v.size() == rd0 + MT + 2) begin
      for (int i = 0; i < MT; i++)
        chk($sformatf("scan.rand%0d", i), 32'({rd_log_v[rd0+i], rd_log_h[rd0+i]}), (6 << 5) | 6);
      chk("scan.p0", 32'({rd_log_v[rd0+MT], rd_log_h[rd0+MT]}), (1 << 5) | 1);
      chk("scan.p1", 32'({rd_log_v[rd0+MT+1], rd_log_h[rd0+MT+1]}), (1 << 5) | 2);
    end
    expect_result("scan", 1'b1, 1, 2, 3 * MT + 5, 1'b1);

    // No empty cell anywhere.
    fill(100);
    snap();
    run_place(-1, 0, 0, 0, 0, 0, 0, 1'b0);
    expect_result("full", 1'b0, 0, 0, 3 * MT + 2 * NCELLS, 1'b1);

    // Randomised grids and candidates against the reference model.
    for (int t = 0; t < 10; t++) begin
      bit rb;
      fill(t == 9 ? 100 : int'($urandom_range(97)));
      cv = int'($urandom_range(31));
      ch = int'($urandom_range(31));
      rb = (t % 3 == 1);
      bus.CandV = 5'(cv); bus.CandH = 5'(ch);
      model(cv, ch, ok, ev, eh, elat);
      snap();
      run_place(-1, 0, 0, 0, 0, 0, 0, rb);
      expect_result($sformatf("rand%0d", t), ok, ev, eh, elat, !rb);
    end

    // Reset while in CHECK aborts with no write.
    fill(0);
    bus.CandV = 5'd5; bus.CandH = 5'd7;
    snap();
    @(negedge clk) bus.PlaceReq = 1'b1;
    @(posedge clk);
    @(negedge clk) bus.PlaceReq = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort.busy_before", 32'(bus.Busy), 1);
    rst = 1'b1;
    #1;
    chk("abort.outputs", 32'({bus.Busy, bus.RdEn, bus.WrEn, bus.PlaceDone, bus.PlaceFail, bus.FoodValid}), 0);
    chk("abort.food", 32'({bus.FoodV, bus.FoodH}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort.idle", 32'(bus.Busy), 0);
    chk("abort.nowrite", wr_cnt - wr0, 0);
    exp_val = 1'b0; exp_fv = 0; exp_fh = 0;
    snap();
    run_place(-1, 0, 0, 0, 0, 0, 0, 1'b0);
    expect_result("after_abort", 1'b1, 5, 7, 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/food_placer.md
# food_placer

Sequencer that owns food placement on the playfield grid. On a placement request it samples candidate coordinates from the food randomizer and probes the grid store through a shared read port. It retries until it finds an empty interior cell, then writes `BLOCK_FOOD` there and reports the new location to game logic. It sits between the randomizer, the grid store and the game FSM, and yields the grid ports to game logic whenever `GridBusy` is high.

## Interface
- `GRID_WIDTH`, default 32: grid columns, including the border walls.
- `GRID_HEIGHT`, default 24: grid rows, including the border walls.
- `BITS_PER_BLOCK`, default 2: width of a cell code.
- `MAX_TRIES`, default 16: random candidates tried before the linear-scan fallback; must be ≥ 1.

- `MasterClock`  in  1: sole clock; all state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `PlaceReq`  in  1: level request; sampled only in IDLE.
- `CandV`  in  clog2(GRID_HEIGHT): randomizer row candidate; may change every cycle.
- `CandH`  in  clog2(GRID_WIDTH): randomizer column candidate.
- `GridBusy`  in  1: game logic owns the grid ports this cycle.
- `RdEn`  out  1: grid read strobe.
- `RdV`, `RdH`  out  row/col width: read address.
- `RdData`  in  BITS_PER_BLOCK: cell code, valid exactly one cycle after an accepted read.
- `WrEn`  out  1: grid write strobe.
- `WrV`, `WrH`  out  row/col width: write address.
- `WrData`  out  BITS_PER_BLOCK: always `BLOCK_FOOD` when `WrEn` is high.
- `Busy`  out  1: state ≠ IDLE.
- `PlaceDone`  out  1: one-cycle pulse, food written.
- `PlaceFail`  out  1: one-cycle pulse, no empty cell exists.
- `FoodValid`  out  1: `FoodV`/`FoodH` hold a placed food location.
- `FoodV`, `FoodH`  out  row/col width: last placed food coordinate.

## Operation
- States:
  - IDLE.
  - SAMPLE.
  - READ.
  - CHECK.
  - SCAN_READ.
  - SCAN_CHECK.
  - WRITE.
  - DONE.
  - FAIL.
- Transitions:
  - IDLE → SAMPLE when `PlaceReq` is high. The tries counter clears. A `PlaceReq` that is high in any other state is ignored.
  - SAMPLE latches `CandV`/`CandH` into the candidate register.
    - Interior candidate (1 ≤ V ≤ GRID_HEIGHT-2 and 1 ≤ H ≤ GRID_WIDTH-2): → READ.
    - Otherwise: tries += 1 and stay in SAMPLE. No read is issued.
  - READ: `RdEn = ~GridBusy` (combinational), address = candidate register. Leaves for CHECK only on an accepted read (`RdEn` high).
  - CHECK compares `RdData` against `BLOCK_EMPTY`.
    - Equal: → WRITE.
    - Not equal: tries += 1 → SAMPLE.
  - Any tries increment that reaches `MAX_TRIES` goes to SCAN_READ instead. The scan pointer is set to (1,1).
  - SCAN_READ / SCAN_CHECK behave like READ / CHECK, using the scan pointer.
    - The pointer advances row-major: H increments; after H = GRID_WIDTH-2 it wraps to H = 1 and V increments.
    - A non-empty cell at (GRID_HEIGHT-2, GRID_WIDTH-2) → FAIL.
  - WRITE: `WrEn = ~GridBusy`, address = the coordinate that was found. Leaves for DONE only on an accepted write.
  - DONE: `PlaceDone` = 1; `FoodV`/`FoodH` load the found coordinate; `FoodValid` = 1. → IDLE.
  - FAIL: `PlaceFail` = 1; food registers unchanged. → IDLE.
- `RdEn` and `WrEn` are never high in the same cycle. Neither is ever high while `GridBusy` is high.

## Timing
- Reset (asynchronous, any state): state = IDLE; all outputs 0; counters, candidate and scan pointer = 0. Reset overrides a simultaneous `PlaceReq`.
- Reset mid-operation aborts immediately; no `WrEn` occurs afterwards.
- Best case, with `PlaceReq` sampled at edge k and `GridBusy` low throughout:
  - SAMPLE during cycle k..k+1.
  - `RdEn` during cycle k+1..k+2.
  - `RdData` checked during cycle k+2..k+3.
  - `WrEn` during cycle k+3..k+4.
  - `PlaceDone` and new `FoodV`/`FoodH` during cycle k+4..k+5.
- Each rejected in-bounds candidate adds 3 cycles; each out-of-bounds candidate adds 1.
- Each `GridBusy` cycle in READ, SCAN_READ or WRITE adds 1 cycle. State and addresses are held stable while stalled.
- Worst case is bounded: MAX_TRIES·3 + 2·(GRID_HEIGHT-2)·(GRID_WIDTH-2) + 3 cycles, excluding `GridBusy` stalls.

## Structure
- Shared package `snake_pkg`:
  - `BLOCK_EMPTY`, `BLOCK_WALL`, `BLOCK_SNAKE`, `BLOCK_FOOD` codes.
  - Default grid dimensions and `BITS_PER_BLOCK`.
  - Row/column coordinate typedefs.
- State enum is local to `food_placer`.
- One sub-module, `food_scan_counter`: row-major interior pointer with load-to-(1,1), advance, and a last-cell flag.

## Test plan
- Empty interior, `CandV`=5, `CandH`=7 constant; pulse `PlaceReq` → `RdEn` at (5,7), then `WrEn` with `WrData`=`BLOCK_FOOD` at (5,7). `PlaceDone` appears 4 cycles after the sample edge with `FoodV`=5, `FoodH`=7, `FoodValid`=1.
- Candidate (0,7) for one cycle, then (3,3) → no read for (0,7); tries = 1; food placed at (3,3) with `PlaceDone` one cycle later than the best case.
- `GridBusy` high for 10 cycles while in READ, then for 3 cycles while in WRITE → `RdEn`/`WrEn` stay low; addresses stay stable; `PlaceDone` arrives 13 cycles late.
- `MAX_TRIES`=4, candidate fixed on a snake cell, (1,1) snake, (1,2) empty → exactly 4 random reads, then scan reads (1,1) and (1,2), then a write to (1,2) and `PlaceDone`.
- Every interior cell non-empty → scan reaches (GRID_HEIGHT-2, GRID_WIDTH-2), `PlaceFail` pulses once, no `WrEn`, food registers unchanged.
- `Reset` asserted in CHECK → all outputs 0 in the same cycle, no `WrEn`. After release, IDLE waits for `PlaceReq`.
